// File: rtl/wb_sched.sv
// Writeback scheduler: round-robin arbitration of two writeback requesters onto one register-file write port, plus a pending-write scoreboard.
// Latency: a granted request appears on d_we/d_addr/d_data one cycle after its handshake edge; s_busy/t_busy come combinationally from registered state.
// Backpressure: at most one of a_ready/b_ready is high per cycle; the loser holds valid and wins next cycle because the pointer alternates.
module wb_sched #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [ADDR_SIZE-1:0] issue_addr,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [WORD_SIZE-1:0] a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [WORD_SIZE-1:0] b_data,
  output logic                 d_we,
  output logic [ADDR_SIZE-1:0] d_addr,
  output logic [WORD_SIZE-1:0] d_data,
  input  logic [ADDR_SIZE-1:0] s_addr,
  input  logic [ADDR_SIZE-1:0] t_addr,
  output logic                 s_busy,
  output logic                 t_busy
);

  localparam int NREG = 2 ** ADDR_SIZE;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] data;
  } wb_t;

  prio_e           prio_q, prio_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            a_gnt, b_gnt, any_gnt;
  wb_t             sel;

  // Grant: the favoured requester wins a collision; a lone requester always wins.
  always_comb begin
    a_gnt   = a_valid && ((prio_q == PRIO_A) || !b_valid);
    b_gnt   = b_valid && ((prio_q == PRIO_B) || !a_valid);
    any_gnt = a_gnt || b_gnt;
    sel     = b_gnt ? wb_t'{addr: b_addr, data: b_data} : wb_t'{addr: a_addr, data: a_data};
  end

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;

  // Pointer next state: favour whichever requester was not just granted.
  always_comb begin
    prio_d = prio_q;
    if (a_gnt) begin
      prio_d = PRIO_B;
    end else if (b_gnt) begin
      prio_d = PRIO_A;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Busy next state: clear on writeback first so a same-edge issue to the same register wins; r0 never pends.
  always_comb begin
    busy_d = busy_q;
    if (any_gnt) begin
      busy_d[sel.addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register-file write port: capture the granted request; writes to r0 update addr/data but never strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_we   <= 1'b0;
      d_addr <= '0;
      d_data <= '0;
    end else begin
      d_we <= any_gnt && (sel.addr != '0);
      if (any_gnt) begin
        d_addr <= sel.addr;
        d_data <= sel.data;
      end
    end
  end

  // Hazard lookup from registered state only, no same-cycle bypass.
  assign s_busy = busy_q[s_addr];
  assign t_busy = busy_q[t_addr];

endmodule
